fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side drain stage for the asynchronous FIFO, in the read clock domain. It pops words from the FIFO read port (`rempty`/`rinc`/`rdata`) and presents them downstream as a registered valid/ready stream through a 2-entry skid buffer. Downstream back-pressure therefore never stalls or corrupts the FIFO pointers, and sustained throughput is one word per `rclk`.

## Interface
Parameters:
- `DSIZE`, 8, data word width; must match the FIFO `DSIZE`.
- `CSIZE`, 16, width of the delivered-word counter.

Ports:
- `rclk`  in  1  read-domain clock; all state updates on its rising edge.
- `rrst_n`  in  1  reset, synchronous, active-low.
- `rempty`  in  1  FIFO empty flag, synchronous to `rclk`.
- `rdata`  in  DSIZE  FIFO show-ahead read data; valid whenever `rempty`=0.
- `rinc`  out  1  FIFO pop strobe; combinational.
- `flush`  in  1  synchronous discard of all buffered words.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DSIZE  output word; registered.
- `rd_count`  out  CSIZE  count of delivered words (see Configuration).

## Operation
- Internal state:
  - 2-entry buffer `buf[0..1]`.
  - Head pointer (1 bit), tail pointer (1 bit), occupancy `cnt` (0..2).
- Pop rule: `rinc = rrst_n & ~rempty & ~flush & (cnt != 2)`.
  - `rinc` has no combinational path from `m_ready`.
- Push: when `rinc`=1, `rdata` is written to `buf[tail]` at the clock edge, and `tail` toggles.
- Output: `m_valid = (cnt != 0)`. `m_data = buf[head]`.
- Transfer: when `m_valid & m_ready`, `head` toggles at the edge.
- Occupancy update:
  - `cnt` +1 on push only.
  - `cnt` −1 on transfer only.
  - `cnt` unchanged when push and transfer occur in the same cycle.
- Ordering is strictly FIFO. No word is duplicated or dropped except by `flush`.
- `m_data` and `m_valid` must hold stable while `m_valid`=1 and `m_ready`=0.
- Flush:
  - At the edge, `cnt`, `head` and `tail` clear.
  - `rinc` is forced to 0 during the flush cycle, so no new word is popped.
  - Any transfer asserted in the flush cycle is ignored; flush wins.
- Reset (`rrst_n`=0 at the edge):
  - `cnt`=0, `head`=0, `tail`=0, all `buf` entries=0.
  - `m_valid`=0, `m_data`=0, `rd_count`=0.
  - `rinc`=0 combinationally for as long as `rrst_n`=0.
- Reset mid-operation discards buffered words. Words already popped from the FIFO are lost, which is acceptable because the FIFO read side is reset together with this block.

## Timing
- Latency: a word popped in cycle N (`rinc`=1) appears with `m_valid`=1 in cycle N+1.
- Throughput: one word per cycle when `rempty`=0 and `m_ready`=1. Steady state is `cnt`=1, with push and transfer every cycle.
- Back-pressure:
  - With `m_ready`=0, at most 2 further words are popped.
  - `rinc` drops in the cycle after `cnt` reaches 2.
- Recovery: after `m_ready` rises with `cnt`=2, popping resumes in the cycle after the first transfer, since `cnt` must first fall to 1.
- `rempty` rising: `rinc` deasserts in the same cycle, and buffered words continue to drain.
- First cycle after reset release: `rinc` may assert if `rempty`=0.

## Configuration
- `FIFO_RD_STREAM_COUNT_EN` defined:
  - `rd_count` increments by 1 on every transfer (`m_valid & m_ready` with `flush`=0).
  - It wraps from 2^CSIZE−1 to 0.
  - It clears only on reset, not on flush.
- Macro undefined: no counter logic is built, and `rd_count` is tied to 0.

## Test plan
- Basic stream: reset, then push 0x11,0x22,0x33 into the FIFO with `m_ready`=1 → `m_data` shows 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its `rinc`. `rd_count`=3 (macro on) or 0 (macro off).
- Back-pressure: 5 words available, `m_ready`=0 for 6 cycles → exactly 2 `rinc` pulses, `m_valid`=1, `m_data`=first word held stable. Releasing `m_ready` then delivers all 5 words in order.
- Simultaneous push and transfer: continuous words with `m_ready`=1 → `cnt` stays at 1, and `rinc` stays high every cycle until `rempty`.
- Flush: with `cnt`=2 (0xA0,0xA1 buffered), assert `flush` for 1 cycle with `m_ready`=1 → no `rinc` that cycle, `m_valid`=0 next cycle, and the next delivered word is the FIFO's following word, not 0xA0/0xA1.
- Reset mid-operation: with `cnt`=2, pull `rrst_n` low for 1 cycle → `m_valid`=0, `m_data`=0, `rd_count`=0, and `rinc`=0 throughout the reset.
- Counter wrap (macro on, `CSIZE`=4): deliver 17 words → `rd_count` reads 0xF after 15 words, 0x0 after 16, and 0x1 after 17.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for the asynchronous FIFO (rclk domain).
// Pops words from the FIFO show-ahead read port and presents them as a
// registered valid/ready stream through a 2-entry skid buffer.
//
// Ports:
//   rclk, rrst_n        clock, synchronous active-low reset
//   rempty, rdata, rinc FIFO read port (rinc is combinational)
//   flush               synchronous discard of buffered words
//   m_valid, m_ready,   downstream stream, m_valid/m_data registered
//   m_data
//   rd_count            delivered-word counter
//
// Optional feature: define FIFO_RD_STREAM_COUNT_EN to build the rd_count
// counter; otherwise rd_count is tied to zero.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [CSIZE-1:0] rd_count
);

  logic [1:0][DSIZE-1:0] buf_mem, buf_n;
  logic                  head, head_n;
  logic                  tail, tail_n;
  logic [1:0]            cnt, cnt_n;
  logic                  push;
  logic                  xfer;

  // Pop decision depends only on local occupancy, never on m_ready.
  always_comb begin
    rinc = rrst_n & ~rempty & ~flush & (cnt != 2'd2);
    push = rinc;
    xfer = m_valid & m_ready & ~flush;
  end

  always_comb begin
    buf_n  = buf_mem;
    head_n = head;
    tail_n = tail;
    cnt_n  = cnt;
    if (flush) begin
      head_n = 1'b0;
      tail_n = 1'b0;
      cnt_n  = 2'd0;
    end else begin
      if (push) begin
        buf_n[tail] = rdata;
        tail_n      = ~tail;
      end
      if (xfer) begin
        head_n = ~head;
      end
      case ({push, xfer})
        2'b10:   cnt_n = cnt + 2'd1;
        2'b01:   cnt_n = cnt - 2'd1;
        default: cnt_n = cnt;
      endcase
    end
  end

  // m_data/m_valid are registered from the next-state view of buf/head/cnt,
  // so they always equal buf[head] and (cnt != 0) after each edge.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf_mem <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      cnt     <= 2'd0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      buf_mem <= buf_n;
      head    <= head_n;
      tail    <= tail_n;
      cnt     <= cnt_n;
      m_valid <= (cnt_n != 2'd0);
      m_data  <= buf_n[head_n];
    end
  end

`ifdef FIFO_RD_STREAM_COUNT_EN
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rd_count <= '0;
    end else if (xfer) begin
      rd_count <= rd_count + 1'b1;
    end
  end
`else
  assign rd_count = '0;
`endif

endmodule
